// File: rtl/param_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_pkg
// Brief    : Shared opcodes, FSM states and default widths for param_datapath.
// Revision : 1.0
// ============================================================================
package datapath_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 16;
  localparam int NUM_ALU_OPS      = 13;
  localparam int ALU_OP_W         = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SHR  = 4'd4,
    ALU_SHRA = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_ROR  = 4'd7,
    ALU_ROL  = 4'd8,
    ALU_NEG  = 4'd9,
    ALU_NOT  = 4'd10,
    ALU_MUL  = 4'd11,
    ALU_DIV  = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  function automatic logic is_single_cycle(input logic [ALU_OP_W-1:0] op);
    return op <= ALU_NOT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : param_datapath_if
// Brief    : Control/memory-side signal bundle of param_datapath.
// Revision : 1.0
// ============================================================================
interface param_datapath_if
  import datapath_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS
);
  localparam int RSEL_W = $clog2(NUM_REGS);

  logic [RSEL_W-1:0]   reg_in_sel;
  logic                reg_in;
  logic [RSEL_W-1:0]   reg_out_sel;
  logic                reg_out;
  logic                PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, MDRread;
  logic                HIin, HIout, LOin, LOout, Yin, Zin, Zhighout, Zlowout;
  logic [DATA_W-1:0]   mdata_in;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_start;
  logic                alu_busy;
  logic                alu_done;
  logic                div_zero;
  logic                bus_conflict;
  logic [DATA_W-1:0]   ir_out, mar_out, mdr_out, pc_out, bus_out;

  modport master (
    output reg_in_sel, reg_in, reg_out_sel, reg_out,
    output PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, MDRread,
    output HIin, HIout, LOin, LOout, Yin, Zin, Zhighout, Zlowout,
    output mdata_in, alu_op, alu_start,
    input  alu_busy, alu_done, div_zero, bus_conflict,
    input  ir_out, mar_out, mdr_out, pc_out, bus_out
  );

  modport slave (
    input  reg_in_sel, reg_in, reg_out_sel, reg_out,
    input  PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, MDRread,
    input  HIin, HIout, LOin, LOout, Yin, Zin, Zhighout, Zlowout,
    input  mdata_in, alu_op, alu_start,
    output alu_busy, alu_done, div_zero, bus_conflict,
    output ir_out, mar_out, mdr_out, pc_out, bus_out
  );
endinterface
`default_nettype wire

// File: rtl/param_datapath_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Sequential signed Booth multiplier / restoring divider with FSM.
//            Divider present only when DATAPATH_DIV_EN is defined.
// Revision : 1.0
// ============================================================================
module muldiv_seq
  import datapath_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic                div_zero,
  output logic                z_we,
  output logic [DATA_W-1:0]   z_hi,
  output logic [DATA_W-1:0]   z_lo
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  fsm_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   acc_q, acc_d;
  logic [DATA_W-1:0] mq_q, mq_d, m_q, m_d;
  logic              qm1_q, qm1_d;
  logic              is_div_q, is_div_d;
  logic              dz_q, dz_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   booth_m, booth_sum;
  logic              start_ok, last_step;
`ifdef DATAPATH_DIV_EN
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [DATA_W:0]   div_shift, div_diff;
`endif

  assign start_ok  = (state_q == IDLE) && start && ((op == ALU_MUL) || (op == ALU_DIV));
  assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    booth_m   = {m_q[DATA_W-1], m_q};
    booth_sum = acc_q;
`ifdef DATAPATH_DIV_EN
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    div_shift = {acc_q[DATA_W-1:0], mq_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, m_q};
`endif
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          dz_d     = 1'b0;
          cnt_d    = '0;
          acc_d    = '0;
          qm1_d    = 1'b0;
          is_div_d = (op == ALU_DIV);
          if (op == ALU_DIV) begin
`ifdef DATAPATH_DIV_EN
            // Divide on magnitudes; signs are reapplied when Z is written.
            neg_a_d = a[DATA_W-1];
            neg_b_d = b[DATA_W-1];
            mq_d    = a[DATA_W-1] ? -a : a;
            m_d     = b[DATA_W-1] ? -b : b;
            state_d = RUN;
`else
            state_d = DONE;
`endif
          end else begin
            mq_d    = b;
            m_d     = a;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
`ifdef DATAPATH_DIV_EN
          if (m_q == '0) begin
            state_d = DONE;
          end else begin
            if (div_diff[DATA_W]) begin
              acc_d = div_shift;
              mq_d  = {mq_q[DATA_W-2:0], 1'b0};
            end else begin
              acc_d = div_diff;
              mq_d  = {mq_q[DATA_W-2:0], 1'b1};
            end
            if (last_step) state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end else begin
          case ({mq_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + booth_m;
            2'b10:   booth_sum = acc_q - booth_m;
            default: booth_sum = acc_q;
          endcase
          acc_d = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
          mq_d  = {booth_sum[0], mq_q[DATA_W-1:1]};
          qm1_d = mq_q[0];
          if (last_step) state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef DATAPATH_DIV_EN
        if (is_div_q && (m_q == '0)) dz_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Result is presented during DONE and captured into Z at the edge that ends it.
  always_comb begin
    z_we = 1'b0;
    z_hi = '0;
    z_lo = '0;
    if (state_q == DONE) begin
      if (!is_div_q) begin
        z_we = 1'b1;
        z_hi = acc_q[DATA_W-1:0];
        z_lo = mq_q;
      end
`ifdef DATAPATH_DIV_EN
      else if (m_q == '0) begin
        z_we = 1'b1;
        z_lo = '1;
        z_hi = neg_a_q ? -mq_q : mq_q;
      end else begin
        z_we = 1'b1;
        z_lo = (neg_a_q ^ neg_b_q) ? -mq_q : mq_q;
        z_hi = neg_a_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      m_q      <= m_d;
      qm1_q    <= qm1_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

`ifdef DATAPATH_DIV_EN
  always_ff @(posedge clock) begin
    if (clear) begin
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
    end
  end
`endif

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
`default_nettype wire

// File: rtl/param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : param_datapath
// Brief    : Parametrised bus datapath: register file, bus mux, single-cycle
//            ALU and sequential MUL/DIV. Divider enabled by DATAPATH_DIV_EN.
// Revision : 1.0
// ============================================================================
module param_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
  input  logic            clock,
  input  logic            clear,
  param_datapath_if.slave dp
);
  localparam int RSEL_W = $clog2(NUM_REGS);
  localparam int SH_W   = $clog2(DATA_W);

  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [DATA_W-1:0] gpr_d [NUM_REGS];
  logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, y_q, y_d, zhi_q, zhi_d, zlo_q, zlo_d;
  logic [6:0]        src_en;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_res;
  logic [SH_W-1:0]   shamt;
  logic              md_busy, md_done, md_div_zero, md_z_we;
  logic [DATA_W-1:0] md_z_hi, md_z_lo;

  // A lone driver reaches the bus; none or several give zero.
  always_comb begin
    src_en = {dp.reg_out, dp.PCout, dp.MDRout, dp.HIout, dp.LOout, dp.Zhighout, dp.Zlowout};
    case (src_en)
      7'b100_0000: bus = gpr_q[dp.reg_out_sel];
      7'b010_0000: bus = pc_q;
      7'b001_0000: bus = mdr_q;
      7'b000_1000: bus = hi_q;
      7'b000_0100: bus = lo_q;
      7'b000_0010: bus = zhi_q;
      7'b000_0001: bus = zlo_q;
      default:     bus = '0;
    endcase
  end

  always_comb begin
    shamt   = bus[SH_W-1:0];
    alu_res = '0;
    case (dp.alu_op)
      ALU_ADD:  alu_res = y_q + bus;
      ALU_SUB:  alu_res = y_q - bus;
      ALU_AND:  alu_res = y_q & bus;
      ALU_OR:   alu_res = y_q | bus;
      ALU_SHR:  alu_res = y_q >> shamt;
      ALU_SHRA: alu_res = DATA_W'($signed(y_q) >>> shamt);
      ALU_SHL:  alu_res = y_q << shamt;
      ALU_ROR:  alu_res = (y_q >> shamt) | (y_q << (DATA_W - int'(shamt)));
      ALU_ROL:  alu_res = (y_q << shamt) | (y_q >> (DATA_W - int'(shamt)));
      ALU_NEG:  alu_res = -bus;
      ALU_NOT:  alu_res = ~bus;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    gpr_d = gpr_q;
    if (dp.reg_in) gpr_d[dp.reg_in_sel] = bus;

    pc_d = pc_q;
    if (dp.PCin)       pc_d = bus;
    else if (dp.IncPC) pc_d = pc_q + DATA_W'(1);

    ir_d  = dp.IRin  ? bus : ir_q;
    mar_d = dp.MARin ? bus : mar_q;
    hi_d  = dp.HIin  ? bus : hi_q;
    lo_d  = dp.LOin  ? bus : lo_q;
    y_d   = dp.Yin   ? bus : y_q;
    mdr_d = mdr_q;
    if (dp.MDRin) mdr_d = dp.MDRread ? dp.mdata_in : bus;

    // A completing MUL/DIV takes precedence over a same-cycle Zin.
    zhi_d = zhi_q;
    zlo_d = zlo_q;
    if (md_z_we) begin
      zhi_d = md_z_hi;
      zlo_d = md_z_lo;
    end else if (dp.Zin && is_single_cycle(dp.alu_op)) begin
      zhi_d = '0;
      zlo_d = alu_res;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
    end else begin
      gpr_q <= gpr_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      y_q   <= y_d;
      zhi_q <= zhi_d;
      zlo_q <= zlo_d;
    end
  end

  muldiv_seq #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clock    (clock),
    .clear    (clear),
    .start    (dp.alu_start),
    .op       (dp.alu_op),
    .a        (y_q),
    .b        (bus),
    .busy     (md_busy),
    .done     (md_done),
    .div_zero (md_div_zero),
    .z_we     (md_z_we),
    .z_hi     (md_z_hi),
    .z_lo     (md_z_lo)
  );

  assign dp.alu_busy     = md_busy;
  assign dp.alu_done     = md_done;
  assign dp.div_zero     = md_div_zero;
  assign dp.bus_conflict = ($countones(src_en) > 1);
  assign dp.ir_out       = ir_q;
  assign dp.mar_out      = mar_q;
  assign dp.mdr_out      = mdr_q;
  assign dp.pc_out       = pc_q;
  assign dp.bus_out      = bus;

endmodule
`default_nettype wire

// File: tb/tb_param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_datapath
// Brief    : Directed self-checking bench for param_datapath (32-bit and 8-bit).
// Revision : 1.0
// ============================================================================
module tb_param_datapath;
  import datapath_pkg::*;

  logic clock = 1'b0;
  logic clear;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  param_datapath_if #(.DATA_W(32), .NUM_REGS(16)) d ();
  param_datapath_if #(.DATA_W(8),  .NUM_REGS(4))  e ();

  param_datapath #(.DATA_W(32), .NUM_REGS(16)) u_dut (
    .clock (clock), .clear (clear), .dp (d.slave));
  param_datapath #(.DATA_W(8), .NUM_REGS(4)) u_dut8 (
    .clock (clock), .clear (clear), .dp (e.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic d_idle();
    {d.reg_in, d.reg_out, d.PCin, d.PCout, d.IncPC, d.IRin, d.MARin, d.MDRin} = '0;
    {d.MDRout, d.MDRread, d.HIin, d.HIout, d.LOin, d.LOout, d.Yin, d.Zin} = '0;
    {d.Zhighout, d.Zlowout, d.alu_start} = '0;
    d.reg_in_sel = '0; d.reg_out_sel = '0; d.mdata_in = '0; d.alu_op = '0;
  endtask

  task automatic e_idle();
    {e.reg_in, e.reg_out, e.PCin, e.PCout, e.IncPC, e.IRin, e.MARin, e.MDRin} = '0;
    {e.MDRout, e.MDRread, e.HIin, e.HIout, e.LOin, e.LOout, e.Yin, e.Zin} = '0;
    {e.Zhighout, e.Zlowout, e.alu_start} = '0;
    e.reg_in_sel = '0; e.reg_out_sel = '0; e.mdata_in = '0; e.alu_op = '0;
  endtask

  task automatic d_mdr(input logic [31:0] v);
    d.mdata_in = v; d.MDRin = 1'b1; d.MDRread = 1'b1;
    tick();
    d.MDRin = 1'b0; d.MDRread = 1'b0;
  endtask

  task automatic d_load_y(input logic [31:0] v);
    d_mdr(v);
    d.MDRout = 1'b1; d.Yin = 1'b1;
    tick();
    d.MDRout = 1'b0; d.Yin = 1'b0;
  endtask

  task automatic d_read_z(output logic [63:0] z);
    d.Zhighout = 1'b1; #1; z[63:32] = d.bus_out;
    d.Zhighout = 1'b0; d.Zlowout = 1'b1; #1; z[31:0] = d.bus_out;
    d.Zlowout = 1'b0; #1;
  endtask

  task automatic d_alu(input string tag, input logic [3:0] op, input logic [31:0] b,
                       input logic [31:0] exp);
    logic [63:0] z;
    d_mdr(b);
    d.MDRout = 1'b1; d.alu_op = op; d.Zin = 1'b1;
    tick();
    d.MDRout = 1'b0; d.Zin = 1'b0;
    d_read_z(z);
    chk(tag, z, {32'h0, exp});
  endtask

  // Launches MUL/DIV with B=b and returns edges from start to alu_done (60 = timeout).
  task automatic d_start(input logic [3:0] op, input logic [31:0] b, input logic exp_busy,
                         output int cyc);
    d_mdr(b);
    d.MDRout = 1'b1; d.alu_op = op; d.alu_start = 1'b1;
    tick();
    d.MDRout = 1'b0; d.alu_start = 1'b0;
    chk("busy_after_start", {63'h0, d.alu_busy}, {63'h0, exp_busy});
    cyc = 0;
    while (cyc < 60) begin
      d.alu_start = (cyc == 10);
      tick();
      cyc++;
      if (d.alu_done) break;
    end
    d.alu_start = 1'b0;
  endtask

  task automatic e_start(input logic [3:0] op, input logic [7:0] b, output int cyc);
    e.mdata_in = b; e.MDRin = 1'b1; e.MDRread = 1'b1;
    tick();
    e.MDRin = 1'b0; e.MDRread = 1'b0;
    e.MDRout = 1'b1; e.alu_op = op; e.alu_start = 1'b1;
    tick();
    e.MDRout = 1'b0; e.alu_start = 1'b0;
    cyc = 0;
    while (cyc < 60) begin
      tick();
      cyc++;
      if (e.alu_done) break;
    end
  endtask

  task automatic e_read_z(output logic [15:0] z);
    e.Zhighout = 1'b1; #1; z[15:8] = e.bus_out;
    e.Zhighout = 1'b0; e.Zlowout = 1'b1; #1; z[7:0] = e.bus_out;
    e.Zlowout = 1'b0; #1;
  endtask

  initial begin
    logic [63:0] z;
    logic [15:0] z8;
    int          cyc;
    int          done_seen;

    d_idle(); e_idle();
    clear = 1'b1;
    tick(); tick();
    clear = 1'b0;

    // Reset state
    chk("rst_pc",       {32'h0, d.pc_out},  64'h0);
    chk("rst_ir",       {32'h0, d.ir_out},  64'h0);
    chk("rst_mar",      {32'h0, d.mar_out}, 64'h0);
    chk("rst_mdr",      {32'h0, d.mdr_out}, 64'h0);
    chk("rst_bus",      {32'h0, d.bus_out}, 64'h0);
    chk("rst_flags",    {60'h0, d.alu_busy, d.alu_done, d.div_zero, d.bus_conflict}, 64'h0);
    d_read_z(z);
    chk("rst_z", z, 64'h0);

    // Register path: MDR -> R5 -> R9, also IR/MAR loads
    d_mdr(32'hDEADBEEF);
    d.MDRout = 1'b1; d.reg_in = 1'b1; d.reg_in_sel = 4'd5; d.IRin = 1'b1;
    tick();
    d.MDRout = 1'b0; d.IRin = 1'b0;
    chk("ir_load", {32'h0, d.ir_out}, 64'hDEADBEEF);
    d.reg_out = 1'b1; d.reg_out_sel = 4'd5; d.reg_in_sel = 4'd9; d.MARin = 1'b1;
    tick();
    d.reg_in = 1'b0; d.MARin = 1'b0; d.reg_out_sel = 4'd9;
    #1;
    chk("r9_copy",  {32'h0, d.bus_out}, 64'hDEADBEEF);
    chk("mar_load", {32'h0, d.mar_out}, 64'hDEADBEEF);
    d.reg_out = 1'b0;

    // PC load, then two drivers on the bus
    d_mdr(32'h10);
    d.MDRout = 1'b1; d.PCin = 1'b1;
    tick();
    d.MDRout = 1'b0; d.PCin = 1'b0;
    chk("pc_load", {32'h0, d.pc_out}, 64'h10);
    d.reg_out = 1'b1; d.reg_out_sel = 4'd5; d.PCout = 1'b1;
    #1;
    chk("conflict_flag", {63'h0, d.bus_conflict}, 64'h1);
    chk("conflict_bus",  {32'h0, d.bus_out},      64'h0);
    d.reg_out = 1'b0; d.PCout = 1'b0;
    #1;
    chk("conflict_clear", {63'h0, d.bus_conflict}, 64'h0);

    // PC increment wrap and PCin priority over IncPC
    d_mdr(32'hFFFFFFFF);
    d.MDRout = 1'b1; d.PCin = 1'b1;
    tick();
    d.MDRout = 1'b0; d.PCin = 1'b0; d.IncPC = 1'b1;
    tick();
    d.IncPC = 1'b0;
    chk("pc_wrap", {32'h0, d.pc_out}, 64'h0);
    d_mdr(32'h20);
    d.MDRout = 1'b1; d.PCin = 1'b1; d.IncPC = 1'b1;
    tick();
    d.MDRout = 1'b0; d.PCin = 1'b0; d.IncPC = 1'b0;
    chk("pc_priority", {32'h0, d.pc_out}, 64'h20);

    // MUL: -3 * 0x7FFFFFFF, alu_start poked mid-run must be ignored
    d_load_y(32'hFFFFFFFD);
    d_start(4'd11, 32'h7FFFFFFF, 1'b1, cyc);
    chk("mul_latency", 64'(cyc), 64'd33);
    chk("mul_busy_at_done", {63'h0, d.alu_busy}, 64'h0);
    d_read_z(z);
    chk("mul_result", z, 64'hFFFFFFFE_80000003);
    tick();
    chk("done_pulse_width", {63'h0, d.alu_done}, 64'h0);

    // Single-cycle ALU with A = 0x80000001 (Zhigh must be zeroed after MUL)
    d_load_y(32'h80000001);
    d_alu("alu_ror",     4'd7,  32'h1,        32'hC0000000);
    d_alu("alu_add",     4'd0,  32'hFFFFFFFF, 32'h80000000);
    d_alu("alu_sub",     4'd1,  32'h2,        32'h7FFFFFFF);
    d_alu("alu_and",     4'd2,  32'hF0000001, 32'h80000001);
    d_alu("alu_or",      4'd3,  32'h10,       32'h80000011);
    d_alu("alu_shr",     4'd4,  32'h4,        32'h08000000);
    d_alu("alu_shr_hi",  4'd4,  32'h21,       32'h40000000);
    d_alu("alu_shra",    4'd5,  32'h4,        32'hF8000000);
    d_alu("alu_shl",     4'd6,  32'h1,        32'h00000002);
    d_alu("alu_rol",     4'd8,  32'h1,        32'h00000003);
    d_alu("alu_rol_32",  4'd8,  32'h20,       32'h80000001);
    d_alu("alu_neg",     4'd9,  32'h1,        32'hFFFFFFFF);
    d_alu("alu_not",     4'd10, 32'h1,        32'hFFFFFFFE);
    d_alu("alu_nop13",   4'd13, 32'h5,        32'hFFFFFFFE);

`ifdef DATAPATH_DIV_EN
    d_load_y(32'hFFFFFFEF);
    d_start(4'd12, 32'h5, 1'b1, cyc);
    chk("div_latency", 64'(cyc), 64'd33);
    d_read_z(z);
    chk("div_result", z, 64'hFFFFFFFE_FFFFFFFD);
    d_load_y(32'h9);
    d_start(4'd12, 32'h0, 1'b1, cyc);
    chk("div0_latency", 64'(cyc), 64'd2);
    chk("div0_flag", {63'h0, d.div_zero}, 64'h1);
    d_read_z(z);
    chk("div0_result", z, 64'h00000009_FFFFFFFF);
    d_load_y(32'h80000000);
    d_start(4'd12, 32'hFFFFFFFF, 1'b1, cyc);
    chk("divmin_flag", {63'h0, d.div_zero}, 64'h0);
    d_read_z(z);
    chk("divmin_result", z, 64'h00000000_80000000);
`else
    d_load_y(32'hFFFFFFEF);
    d_start(4'd12, 32'h5, 1'b0, cyc);
    chk("nodiv_latency", 64'(cyc), 64'd1);
    chk("nodiv_flag", {63'h0, d.div_zero}, 64'h0);
    d_read_z(z);
    chk("nodiv_z_kept", z, 64'h00000000_FFFFFFFE);
`endif

    // Clear five cycles into a MUL aborts it without a done pulse
    d_load_y(32'h7);
    d_mdr(32'h3);
    d.MDRout = 1'b1; d.alu_op = 4'd11; d.alu_start = 1'b1;
    tick();
    d.MDRout = 1'b0; d.alu_start = 1'b0;
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_busy", {63'h0, d.alu_busy}, 64'h0);
    chk("abort_pc",   {32'h0, d.pc_out},   64'h0);
    d_read_z(z);
    chk("abort_z", z, 64'h0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (d.alu_done) done_seen++;
      tick();
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);

    // 8-bit, 4-register instance
    e.mdata_in = 8'h80; e.MDRin = 1'b1; e.MDRread = 1'b1;
    tick();
    e.MDRin = 1'b0; e.MDRread = 1'b0; e.MDRout = 1'b1; e.Yin = 1'b1;
    tick();
    e.MDRout = 1'b0; e.Yin = 1'b0;
    e_start(4'd11, 8'h80, cyc);
    chk("mul8_latency", 64'(cyc), 64'd9);
    e_read_z(z8);
    chk("mul8_result", {48'h0, z8}, 64'h4000);
`ifdef DATAPATH_DIV_EN
    e_start(4'd12, 8'hFF, cyc);
    chk("div8_latency", 64'(cyc), 64'd9);
    e_read_z(z8);
    chk("div8_minneg", {48'h0, z8}, 64'h0080);
`else
    e_start(4'd12, 8'hFF, cyc);
    chk("nodiv8_latency", 64'(cyc), 64'd1);
    e_read_z(z8);
    chk("nodiv8_z_kept", {48'h0, z8}, 64'h4000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
